// File: rtl/ql_vmem_port.sv
// ql_vmem_port: slot-based arbiter sharing one SDRAM request port between ZX8301 video
// fetches (slot 0) and CPU/MDV accesses. `VMEM_LATE_CNT_EN adds vid_late_cnt_o.
module ql_vmem_port #(
    parameter int unsigned SLOT_LEN = 8,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    input  logic              vid_rd_i,
    output logic [15:0]       vid_din_o,
    output logic              video_cycle_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    input  logic [1:0]        cpu_be_i,
    output logic              cpu_ack_o,
    output logic [15:0]       cpu_rdata_o,
    output logic              sd_req_o,
    output logic              sd_we_o,
    output logic [ADDR_W-1:0] sd_addr_o,
    output logic [15:0]       sd_wdata_o,
    output logic [1:0]        sd_be_o,
    input  logic              sd_valid_i,
    input  logic [15:0]       sd_rdata_i,
`ifdef VMEM_LATE_CNT_EN
    output logic [15:0]       vid_late_cnt_o,
`endif
    output logic              vid_late_o
);
    localparam int unsigned     CntW     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_LEN - 1);
    localparam logic [CntW-1:0] SlotHalf = CntW'(SLOT_LEN / 2);
    localparam logic [CntW-1:0] SlotDl   = CntW'(SLOT_LEN / 2 - 2);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StVidWait = 2'd1;
    localparam logic [1:0] StCpuWait = 2'd2;

    logic [CntW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]        state_q, state_d;
    logic              video_cycle_q, video_cycle_d;
    logic [15:0]       vid_din_q, vid_din_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic              sd_req_q, sd_req_d;
    logic              sd_we_q, sd_we_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [15:0]       sd_wdata_q, sd_wdata_d;
    logic [1:0]        sd_be_q, sd_be_d;
    logic              vid_late_q, vid_late_d;
    logic              dl_miss_q, dl_miss_d;
    logic              late_ret;
    logic              vid_blocked;

    // Commands are registered, so decisions look one cycle ahead at slot_cnt_d.
    always_comb begin
        slot_cnt_d    = (slot_cnt_q == SlotLast) ? '0 : slot_cnt_q + 1'b1;
        video_cycle_d = (slot_cnt_d < SlotHalf);
        state_d       = state_q;
        vid_din_d     = vid_din_q;
        cpu_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        sd_req_d      = 1'b0;
        sd_we_d       = sd_we_q;
        sd_addr_d     = sd_addr_q;
        sd_wdata_d    = sd_wdata_q;
        sd_be_d       = sd_be_q;
        dl_miss_d     = dl_miss_q;
        late_ret      = 1'b0;
        vid_blocked   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (slot_cnt_d == '0 && vid_rd_i) begin
                    sd_req_d  = 1'b1;
                    sd_we_d   = 1'b0;
                    sd_addr_d = vid_addr_i;
                    sd_be_d   = 2'b11;
                    dl_miss_d = 1'b0;
                    state_d   = StVidWait;
                end else if ((slot_cnt_d == '0 || slot_cnt_d == SlotHalf) && cpu_req_i &&
                             !cpu_ack_q) begin
                    // cpu_ack_q guard: requester still holds cpu_req during its ack cycle.
                    sd_req_d   = 1'b1;
                    sd_we_d    = cpu_we_i;
                    sd_addr_d  = cpu_addr_i;
                    sd_wdata_d = cpu_wdata_i;
                    sd_be_d    = cpu_be_i;
                    state_d    = StCpuWait;
                end
            end
            StVidWait: begin
                if (sd_valid_i) begin
                    vid_din_d = sd_rdata_i;
                    late_ret  = dl_miss_q || (slot_cnt_q > SlotDl);
                    state_d   = StIdle;
                end else if (slot_cnt_q == SlotLast) begin
                    dl_miss_d = 1'b1;
                end
            end
            StCpuWait: begin
                if (sd_valid_i) begin
                    cpu_ack_d = 1'b1;
                    if (!sd_we_q) cpu_rdata_d = sd_rdata_i;
                    state_d = StIdle;
                end
                vid_blocked = (slot_cnt_d == '0) && vid_rd_i;
            end
            default: state_d = StIdle;
        endcase

        vid_late_d = vid_late_q | late_ret | vid_blocked;
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_cnt_q    <= '0;
            state_q       <= StIdle;
            video_cycle_q <= 1'b1;
            vid_din_q     <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            sd_req_q      <= 1'b0;
            sd_we_q       <= 1'b0;
            sd_addr_q     <= '0;
            sd_wdata_q    <= '0;
            sd_be_q       <= '0;
            vid_late_q    <= 1'b0;
            dl_miss_q     <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            state_q       <= state_d;
            video_cycle_q <= video_cycle_d;
            vid_din_q     <= vid_din_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            sd_req_q      <= sd_req_d;
            sd_we_q       <= sd_we_d;
            sd_addr_q     <= sd_addr_d;
            sd_wdata_q    <= sd_wdata_d;
            sd_be_q       <= sd_be_d;
            vid_late_q    <= vid_late_d;
            dl_miss_q     <= dl_miss_d;
        end
    end

`ifdef VMEM_LATE_CNT_EN
    logic [15:0] late_cnt_q, late_cnt_d;

    assign late_cnt_d = (late_ret && late_cnt_q != 16'hFFFF) ? late_cnt_q + 16'd1 : late_cnt_q;

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) late_cnt_q <= '0;
        else            late_cnt_q <= late_cnt_d;
    end

    assign vid_late_cnt_o = late_cnt_q;
`endif

    assign vid_din_o     = vid_din_q;
    assign video_cycle_o = video_cycle_q;
    assign cpu_ack_o     = cpu_ack_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign sd_req_o      = sd_req_q;
    assign sd_we_o       = sd_we_q;
    assign sd_addr_o     = sd_addr_q;
    assign sd_wdata_o    = sd_wdata_q;
    assign sd_be_o       = sd_be_q;
    assign vid_late_o    = vid_late_q;

endmodule

// File: tb/tb_ql_vmem_port.sv
// tb_ql_vmem_port: directed and randomized checks of ql_vmem_port against a slot-level model
// with a behavioural SDRAM responder (latency per command taken from a queue).
module tb_ql_vmem_port;
    localparam int SL   = 8;
    localparam int HALF = SL / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] vid_addr;
    logic        vid_rd;
    logic [15:0] vid_din;
    logic        video_cycle;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        sd_req;
    logic        sd_we;
    logic [18:0] sd_addr;
    logic [15:0] sd_wdata;
    logic [1:0]  sd_be;
    logic        sd_valid = 1'b0;
    logic [15:0] sd_rdata = 16'h0;
    logic        vid_late;
`ifdef VMEM_LATE_CNT_EN
    logic [15:0] vid_late_cnt;
`endif

    always #5 clk = ~clk;

    ql_vmem_port #(.SLOT_LEN(SL), .ADDR_W(19)) dut (
        .clk_sys_i     (clk),
        .reset_n_i     (rst_n),
        .vid_addr_i    (vid_addr),
        .vid_rd_i      (vid_rd),
        .vid_din_o     (vid_din),
        .video_cycle_o (video_cycle),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_be_i      (cpu_be),
        .cpu_ack_o     (cpu_ack),
        .cpu_rdata_o   (cpu_rdata),
        .sd_req_o      (sd_req),
        .sd_we_o       (sd_we),
        .sd_addr_o     (sd_addr),
        .sd_wdata_o    (sd_wdata),
        .sd_be_o       (sd_be),
        .sd_valid_i    (sd_valid),
        .sd_rdata_i    (sd_rdata),
`ifdef VMEM_LATE_CNT_EN
        .vid_late_cnt_o(vid_late_cnt),
`endif
        .vid_late_o    (vid_late)
    );

    int total = 0;
    int bad   = 0;
    int cyc;

    // Clocks since reset release; cyc % SL is the bus-cycle slot of the current cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [15:0] sdram   [logic [18:0]];
    logic [15:0] ref_mem [logic [18:0]];
    int          lat_q[$];

    // SDRAM model: sd_valid is sampled by the DUT in the slot 'latency' clocks after sd_req.
    logic        p_busy = 1'b0;
    int          p_cnt  = 0;
    logic [18:0] p_addr;
    logic        p_we;
    logic [15:0] p_wd;
    logic [1:0]  p_be;
    always @(negedge clk) begin
        logic [15:0] t;
        sd_valid = 1'b0;
        if (p_busy) begin
            p_cnt = p_cnt - 1;
            if (p_cnt == 0) begin
                p_busy   = 1'b0;
                sd_valid = 1'b1;
                t = sdram.exists(p_addr) ? sdram[p_addr] : 16'h0;
                if (p_we) begin
                    if (p_be[0]) t[7:0] = p_wd[7:0];
                    if (p_be[1]) t[15:8] = p_wd[15:8];
                    sdram[p_addr] = t;
                    sd_rdata = 16'($urandom);
                end else begin
                    sd_rdata = t;
                end
            end
        end
        if (sd_req) begin
            p_busy = 1'b1;
            p_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
            p_addr = sd_addr;
            p_we   = sd_we;
            p_wd   = sd_wdata;
            p_be   = sd_be;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ensure(input logic [18:0] a);
        logic [15:0] w;
        if (!ref_mem.exists(a)) begin
            w = 16'($urandom);
            ref_mem[a] = w;
            sdram[a]   = w;
        end
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 4 * SL; i++) begin
            @(negedge clk);
            if (cyc % SL == s) return;
        end
        check("wait_slot_timeout", 0, 1);
    endtask

    task automatic wait_sdreq(output int s);
        for (int i = 0; i < 5 * SL; i++) begin
            @(negedge clk);
            if (sd_req) begin
                s = cyc % SL;
                return;
            end
        end
        s = -1;
        check("sd_req_timeout", 0, 1);
    endtask

    task automatic wait_ack(output int s);
        for (int i = 0; i < 5 * SL; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                s = cyc % SL;
                return;
            end
        end
        s = -1;
        check("cpu_ack_timeout", 0, 1);
    endtask

    initial begin
        int          s;
        int          seen;
        logic [15:0] exp_rdata;
        logic [15:0] t;
        logic [18:0] a;
        logic [18:0] va;

        exp_rdata = 16'h0;
        rst_n = 1'b0; vid_rd = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle video_cycle waveform.
        check("rst_video_cycle", video_cycle, 1);
        check("rst_vid_din", vid_din, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_sd_req", sd_req, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_vid_late", vid_late, 0);
        seen = 0;
        for (int i = 0; i < 2 * SL; i++) begin
            @(negedge clk);
            check("idle_video_cycle", video_cycle, (cyc % SL) < HALF);
            if (sd_req) seen++;
        end
        check("idle_no_sd_req", seen, 0);

        // Video fetch, latency 2, on time.
        sdram[19'h10000] = 16'hA55A; ref_mem[19'h10000] = 16'hA55A;
        lat_q.push_back(2);
        wait_slot(6);
        vid_addr = 19'h10000; vid_rd = 1'b1;
        wait_sdreq(s);
        check("t2_slot", s, 0);
        check("t2_addr", sd_addr, 19'h10000);
        check("t2_we", sd_we, 0);
        vid_rd = 1'b0;
        wait_slot(HALF - 1);
        check("t2_vid_din", vid_din, 16'hA55A);
        check("t2_vc_high", video_cycle, 1);
        check("t2_late", vid_late, 0);

        // Video and CPU read both pending at slot 0.
        ensure(19'h14002);
        va = 19'($urandom); ensure(va);
        lat_q.push_back(2); lat_q.push_back(3);
        wait_slot(6);
        vid_addr = va; vid_rd = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h14002; cpu_wdata = 16'($urandom); cpu_be = 2'b11;
        wait_sdreq(s);
        check("t3_vid_slot", s, 0);
        check("t3_vid_addr", sd_addr, va);
        vid_rd = 1'b0;
        wait_sdreq(s);
        check("t3_cpu_slot", s, HALF);
        check("t3_cpu_addr", sd_addr, 19'h14002);
        check("t3_cpu_we", sd_we, 0);
        wait_ack(s);
        check("t3_ack_slot", s, 0);
        check("t3_rdata", cpu_rdata, ref_mem[19'h14002]);
        exp_rdata = ref_mem[19'h14002];
        cpu_req = 1'b0;
        check("t3_vid_din", vid_din, ref_mem[va]);
        @(negedge clk);
        check("t3_ack_one_cycle", cpu_ack, 0);

        // CPU byte write at slot 0, then read back.
        a = 19'($urandom); ensure(a);
        lat_q.push_back(2);
        wait_slot(6);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = 16'h1234; cpu_be = 2'b01;
        wait_sdreq(s);
        check("t4_slot", s, 0);
        check("t4_we", sd_we, 1);
        check("t4_be", sd_be, 2'b01);
        check("t4_wdata", sd_wdata, 16'h1234);
        check("t4_addr", sd_addr, a);
        wait_ack(s);
        check("t4_ack_slot", s, 3);
        check("t4_rdata_kept", cpu_rdata, exp_rdata);
        cpu_req = 1'b0;
        t = ref_mem[a]; t[7:0] = 8'h34; ref_mem[a] = t;
        lat_q.push_back(1);
        wait_slot(6);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        wait_sdreq(s);
        wait_ack(s);
        check("t4_readback", cpu_rdata, ref_mem[a]);
        exp_rdata = ref_mem[a];
        cpu_req = 1'b0;

        // Randomized mix of on-time video, CPU reads and writes.
        for (int it = 0; it < 24; it++) begin
            int          k;
            logic [18:0] ra;
            logic [18:0] ca;
            logic [15:0] wd;
            logic [15:0] exp_vid;
            logic [1:0]  be;
            logic        we;
            k  = $urandom_range(1, 3);
            ra = 19'($urandom); ca = 19'($urandom);
            ensure(ra); ensure(ca);
            wd = 16'($urandom); be = 2'($urandom); we = 1'($urandom);
            exp_vid = ref_mem[ra];
            if (k[0]) lat_q.push_back($urandom_range(1, 2));
            if (k[1]) lat_q.push_back($urandom_range(1, 5));
            wait_slot(6);
            if (k[0]) begin vid_addr = ra; vid_rd = 1'b1; end
            if (k[1]) begin
                cpu_req = 1'b1; cpu_we = we; cpu_addr = ca; cpu_wdata = wd; cpu_be = be;
            end
            if (k[0]) begin
                wait_sdreq(s);
                check("rnd_vid_slot", s, 0);
                check("rnd_vid_addr", sd_addr, ra);
                check("rnd_vid_we", sd_we, 0);
                vid_rd = 1'b0;
            end
            if (k[1]) begin
                wait_sdreq(s);
                check("rnd_cpu_slot", s, k[0] ? HALF : 0);
                check("rnd_cpu_addr", sd_addr, ca);
                check("rnd_cpu_we", sd_we, we);
                if (we) begin
                    check("rnd_cpu_wdata", sd_wdata, wd);
                    check("rnd_cpu_be", sd_be, be);
                end
                wait_ack(s);
                if (we) begin
                    check("rnd_wr_rdata_kept", cpu_rdata, exp_rdata);
                    t = ref_mem[ca];
                    if (be[0]) t[7:0] = wd[7:0];
                    if (be[1]) t[15:8] = wd[15:8];
                    ref_mem[ca] = t;
                end else begin
                    check("rnd_rd_rdata", cpu_rdata, ref_mem[ca]);
                    exp_rdata = ref_mem[ca];
                end
                cpu_req = 1'b0;
            end
            if (k[0]) begin
                if (!k[1]) wait_slot(HALF - 1);
                check("rnd_vid_din", vid_din, exp_vid);
                check("rnd_vid_late", vid_late, 0);
            end
        end

        // Late video return (latency 5): captured, vid_late sticky.
        va = 19'($urandom); ensure(va);
        lat_q.push_back(5);
        wait_slot(6);
        vid_addr = va; vid_rd = 1'b1;
        wait_sdreq(s);
        vid_rd = 1'b0;
        wait_slot(7);
        check("t5_vid_din", vid_din, ref_mem[va]);
        check("t5_late", vid_late, 1);
`ifdef VMEM_LATE_CNT_EN
        check("t5_late_cnt", vid_late_cnt, 1);
`endif
        va = 19'($urandom); ensure(va);
        lat_q.push_back(2);
        wait_slot(6);
        vid_addr = va; vid_rd = 1'b1;
        wait_sdreq(s);
        vid_rd = 1'b0;
        wait_slot(HALF - 1);
        check("t5_vid_din2", vid_din, ref_mem[va]);
        check("t5_late_sticky", vid_late, 1);
`ifdef VMEM_LATE_CNT_EN
        check("t5_late_cnt_hold", vid_late_cnt, 1);
`endif

        // Reset mid video access; the stray sd_valid afterwards is ignored.
        va = 19'($urandom); ensure(va);
        lat_q.push_back(4);
        wait_slot(6);
        vid_addr = va; vid_rd = 1'b1;
        wait_sdreq(s);
        vid_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_vid_din", vid_din, 0);
        check("t6_late_clr", vid_late, 0);
        check("t6_video_cycle", video_cycle, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t6_video_cycle_run", video_cycle, (cyc % SL) < HALF);
            if (cpu_ack || sd_req) seen++;
        end
        check("t6_no_ack_no_req", seen, 0);
        check("t6_vid_din_after", vid_din, 0);

        // CPU access still in flight at slot 0 delays video one bus cycle.
        a = 19'($urandom); ensure(a);
        va = 19'($urandom); ensure(va);
        lat_q.push_back(7); lat_q.push_back(2);
        wait_slot(2);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        wait_sdreq(s);
        check("blk_cpu_slot", s, HALF);
        wait_slot(6);
        vid_addr = va; vid_rd = 1'b1;
        wait_ack(s);
        check("blk_ack_slot", s, HALF);
        check("blk_rdata", cpu_rdata, ref_mem[a]);
        cpu_req = 1'b0;
        check("blk_late", vid_late, 1);
        check("blk_vid_din_old", vid_din, 0);
        wait_sdreq(s);
        check("blk_vid_slot", s, 0);
        check("blk_vid_addr", sd_addr, va);
        vid_rd = 1'b0;
        wait_slot(HALF - 1);
        check("blk_vid_din", vid_din, ref_mem[va]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
